// File: rtl/mole_hit_detector_pkg.sv
// Shared types and helpers for the mole hit detector: default sizing,
// the evaluation FSM state encoding and a lowest-set-bit picker.
package mole_pkg;

  localparam int NUM_MOLES_DEF = 32'sd9;

  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_MOLES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_REPORT = 2'd2
  } hit_state_e;

  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] idx;
    logic       found;
    idx   = 4'd0;
    found = 1'b0;
    for (int i = 32'sd0; i < 32'sd16; i++) begin
      if (mask[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mole_hit_detector_switch_debounce.sv
// Single-bit switch conditioner: 2-FF synchroniser, stability counter and a
// one-cycle event on every accepted change in either direction.
module switch_debounce #(
  parameter int DEBOUNCE_CLKS = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic event_pulse
);

  localparam int CNT_W = (DEBOUNCE_CLKS > 32'sd1) ? $clog2(DEBOUNCE_CLKS) : 32'sd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLKS - 32'sd1);

  logic             sync1_r;
  logic             sync2_r;
  logic             loaded_r;
  logic             accepted_r;
  logic [CNT_W-1:0] cnt_r;
  logic             event_r;

  // Synchroniser flops keep tracking through reset so the first post-reset
  // accepted value is the real switch level and no event fires for it.
  always_ff @(posedge clk) begin
    sync1_r <= sw_raw;
    sync2_r <= sync1_r;
  end

  // Accept a change only after it has been seen on DEBOUNCE_CLKS consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_r   <= 1'b0;
      accepted_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      event_r    <= 1'b0;
    end else if (!loaded_r) begin
      loaded_r   <= 1'b1;
      accepted_r <= sync2_r;
      cnt_r      <= {CNT_W{1'b0}};
      event_r    <= 1'b0;
    end else if (sync2_r == accepted_r) begin
      cnt_r      <= {CNT_W{1'b0}};
      event_r    <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      accepted_r <= sync2_r;
      cnt_r      <= {CNT_W{1'b0}};
      event_r    <= 1'b1;
    end else begin
      cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      event_r    <= 1'b0;
    end
  end

  assign event_pulse = event_r;

endmodule

// File: rtl/mole_hit_detector.sv
// Turns debounced mole-switch toggles into whack events, scores them against
// the lit-mole mask and reports hits (valid/ready) or misses (pulse).
module mole_hit_detector
  import mole_pkg::*;
#(
  parameter int NUM_MOLES     = NUM_MOLES_DEF,
  parameter int DEBOUNCE_CLKS = 2500000,
  parameter int IDX_W         = idx_width(NUM_MOLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_MOLES-1:0] switches,
  input  logic [NUM_MOLES-1:0] mole_active,
  input  logic                 game_active,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic [IDX_W-1:0]     hit_index,
  output logic [NUM_MOLES-1:0] clear_mole,
  output logic                 miss_pulse,
  output logic [15:0]          hit_count
);

  localparam logic [NUM_MOLES-1:0] ONE_MASK = {{(NUM_MOLES-1){1'b0}}, 1'b1};
  localparam logic [NUM_MOLES-1:0] NO_MASK  = {NUM_MOLES{1'b0}};

  logic [NUM_MOLES-1:0] event_s;
  logic [NUM_MOLES-1:0] cand_s;
  logic [NUM_MOLES-1:0] pending_r, pending_nxt_s;
  logic [IDX_W-1:0]     sel_r, sel_nxt_s;
  hit_state_e           state_r, state_nxt_s;
  logic                 game_d_r;
  logic                 hit_valid_r, hit_valid_nxt_s;
  logic [IDX_W-1:0]     hit_index_r, hit_index_nxt_s;
  logic [NUM_MOLES-1:0] clear_r, clear_nxt_s;
  logic                 miss_r, miss_nxt_s;
  logic [15:0]          count_r, count_nxt_s;

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_db
    switch_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_raw      (switches[g]),
      .event_pulse (event_s[g])
    );
  end

  // Fresh events are visible to IDLE in the same cycle they arrive.
  assign cand_s = pending_r | event_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (game_active && (cand_s != NO_MASK)) state_nxt_s = ST_EVAL;
                 else                                    state_nxt_s = ST_IDLE;
      ST_EVAL:   if (mole_active[sel_r]) state_nxt_s = ST_REPORT;
                 else                    state_nxt_s = ST_IDLE;
      ST_REPORT: if (hit_ready) state_nxt_s = ST_IDLE;
                 else           state_nxt_s = ST_REPORT;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values (registered below).
  always_comb begin
    sel_nxt_s       = sel_r;
    pending_nxt_s   = pending_r;
    hit_valid_nxt_s = hit_valid_r;
    hit_index_nxt_s = hit_index_r;
    clear_nxt_s     = NO_MASK;
    miss_nxt_s      = 1'b0;
    count_nxt_s     = count_r;

    if (!game_active) begin
      pending_nxt_s = NO_MASK;
    end else if ((state_r == ST_IDLE) && (cand_s != NO_MASK)) begin
      sel_nxt_s     = IDX_W'(lowest_set(16'(cand_s)));
      pending_nxt_s = cand_s & ~(ONE_MASK << sel_nxt_s);
    end else begin
      pending_nxt_s = cand_s;
    end

    case (state_r)
      ST_EVAL: begin
        if (mole_active[sel_r]) begin
          clear_nxt_s     = ONE_MASK << sel_r;
          hit_valid_nxt_s = 1'b1;
          hit_index_nxt_s = sel_r;
          count_nxt_s     = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
        end else begin
          miss_nxt_s      = 1'b1;
        end
      end
      ST_REPORT: begin
        if (hit_ready) hit_valid_nxt_s = 1'b0;
        else           hit_valid_nxt_s = 1'b1;
      end
      default: hit_valid_nxt_s = 1'b0;
    endcase

    if (game_active && !game_d_r) count_nxt_s = 16'd0;
    else                          count_nxt_s = count_nxt_s;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= NO_MASK;
      sel_r       <= {IDX_W{1'b0}};
      game_d_r    <= 1'b0;
      hit_valid_r <= 1'b0;
      hit_index_r <= {IDX_W{1'b0}};
      clear_r     <= NO_MASK;
      miss_r      <= 1'b0;
      count_r     <= 16'd0;
    end else begin
      pending_r   <= pending_nxt_s;
      sel_r       <= sel_nxt_s;
      game_d_r    <= game_active;
      hit_valid_r <= hit_valid_nxt_s;
      hit_index_r <= hit_index_nxt_s;
      clear_r     <= clear_nxt_s;
      miss_r      <= miss_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

  assign hit_valid  = hit_valid_r;
  assign hit_index  = hit_index_r;
  assign clear_mole = clear_r;
  assign miss_pulse = miss_r;
  assign hit_count  = count_r;

endmodule
